seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 14 +
 rtl/sub_lookahead.sv | 44 ++++
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default operand width and the FSM state encoding used by
// seq_divider.
package div_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_lookahead.sv
// Combinational N-bit subtractor built from a carry-lookahead adder that
// computes a + ~b + 1.
// Ports:
//   a, b   : N-bit unsigned operands
//   diff   : a - b (modulo 2^N)
//   borrow : high when a < b
module sub_lookahead #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] prop;
  logic [N-1:0] gen;
  logic [N:0]   carry;
  logic         acc;
  logic         prod;

  // Each carry is expanded directly from generate/propagate terms and the
  // carry-in of 1, rather than rippling from the previous carry.
  always_comb begin
    prop  = a ^ ~b;
    gen   = a & ~b;
    carry = '0;
    acc   = 1'b0;
    prod  = 1'b1;
    carry[0] = 1'b1;
    for (int i = 1; i <= N; i++) begin
      acc  = gen[i-1];
      prod = prop[i-1];
      for (int j = i - 2; j >= 0; j--) begin
        acc  = acc | (prod & gen[j]);
        prod = prod & prop[j];
      end
      carry[i] = acc | prod;
    end
    diff   = prop ^ carry[N-1:0];
    borrow = ~carry[N];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : request pulse, only honoured in IDLE
//   dividend     : numerator, captured on acceptance
//   divisor      : denominator, captured on acceptance
//   busy         : high from the cycle after acceptance through the done cycle
//   done         : one-cycle pulse when results are valid
//   quotient     : registered quotient (all ones on divide by zero)
//   remainder    : registered remainder (dividend on divide by zero)
//   div_by_zero  : registered flag, set when the captured divisor was 0
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_acc;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_diff;
  logic             sub_borrow;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] step_quo;

  sub_lookahead #(
    .N(WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_reg}),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // One restoring step. When the subtraction borrows, the shifted value is
  // smaller than the divisor and therefore fits back into WIDTH bits.
  always_comb begin
    shifted  = {part_rem, dvd_reg[WIDTH-1]};
    step_bit = ~sub_borrow;
    step_rem = sub_borrow ? shifted[WIDTH-1:0] : sub_diff[WIDTH-1:0];
    step_quo = (quo_acc << 1) | WIDTH'(step_bit);
  end

  // Next-state and status decode; busy covers both CALC and FIN.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (divisor == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == '0) begin
          next_state = FIN;
        end
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State and datapath registers. Results only change on the edge that
  // enters FIN, so they hold steady between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      part_rem    <= '0;
      quo_acc     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg  <= dividend;
            dvs_reg  <= divisor;
            part_rem <= '0;
            quo_acc  <= '0;
            count    <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd_reg  <= dvd_reg << 1;
          part_rem <= step_rem;
          quo_acc  <= step_quo;
          if (count == '0) begin
            quotient    <= step_quo;
            remainder   <= step_rem;
            div_by_zero <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus an exhaustive
// sweep of all operand pairs, with expected results held in a scoreboard.
module tb_seq_divider;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  exp_t sb[$];
  int   checks;
  int   errors;

  seq_divider #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result from plain integer division.
  task automatic pushExpected(input logic [3:0] dvd, input logic [3:0] dvs);
    exp_t e;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 4'd0) begin
      e.q   = 4'hF;
      e.r   = dvd;
      e.dbz = 1'b1;
    end else begin
      e.q   = dvd / dvs;
      e.r   = dvd % dvs;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Drive a request at the current negedge and record its expectation.
  task automatic applyStimulus(input logic [3:0] dvd, input logic [3:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    pushExpected(dvd, dvs);
  endtask

  // Wait (bounded) for done, measuring negedges since the request was
  // driven; operands are replaced right after acceptance to show they are
  // not reused. Then check the result and that done is a single pulse.
  task automatic checkOutput(input int exp_lat, input bit hold,
                             input logic [3:0] nd, input logic [3:0] nv,
                             input string tag);
    int   n;
    bit   seen;
    exp_t e;
    seen = 1'b0;
    n    = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (!hold) start = 1'b0;
        dividend = nd;
        divisor  = nv;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    checkVal({tag, " done seen"}, 32'(seen), 32'd1);
    checkVal({tag, " latency"}, 32'(n), 32'(exp_lat));
    if (sb.size() == 0) begin
      checkVal({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkVal({tag, " quotient"}, 32'(quotient), 32'(e.q));
      checkVal({tag, " remainder"}, 32'(remainder), 32'(e.r));
      checkVal({tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
      checkVal({tag, " busy at done"}, 32'(busy), 32'd1);
      if (e.dvs != 4'd0) begin
        checkVal({tag, " q*d+r"}, 32'(quotient) * 32'(e.dvs) + 32'(remainder), 32'(e.dvd));
        checkVal({tag, " r<d"}, 32'(remainder < e.dvs), 32'd1);
      end
    end
    @(negedge clk);
    checkVal({tag, " done pulse ends"}, 32'(done), 32'd0);
    checkVal({tag, " busy ends"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit saw_done;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd0;

    // Reset, with start held high to show it is ignored under reset.
    @(negedge clk);
    @(negedge clk);
    checkVal("reset busy", 32'(busy), 32'd0);
    checkVal("reset done", 32'(done), 32'd0);
    checkVal("reset quotient", 32'(quotient), 32'd0);
    checkVal("reset remainder", 32'(remainder), 32'd0);
    checkVal("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkVal("idle after reset busy", 32'(busy), 32'd0);

    $display("[TB] 13 / 3");
    applyStimulus(4'd13, 4'd3);
    checkOutput(5, 1'b0, 4'd0, 4'd0, "t13_3");

    $display("[TB] 9 / 0");
    applyStimulus(4'd9, 4'd0);
    checkOutput(1, 1'b0, 4'd1, 4'd1, "t9_0");

    $display("[TB] 2 / 7 with operands changed mid-CALC");
    applyStimulus(4'd2, 4'd7);
    checkOutput(5, 1'b0, 4'd15, 4'd1, "t2_7");

    $display("[TB] 15 / 1 with start held, then 11 / 2");
    applyStimulus(4'd15, 4'd1);
    pushExpected(4'd11, 4'd2);
    checkOutput(5, 1'b1, 4'd11, 4'd2, "t15_1");
    checkOutput(5, 1'b0, 4'd3, 4'd9, "t11_2");

    $display("[TB] reset during second CALC cycle");
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("abort busy", 32'(busy), 32'd0);
    checkVal("abort done", 32'(done), 32'd0);
    checkVal("abort quotient", 32'(quotient), 32'd0);
    checkVal("abort remainder", 32'(remainder), 32'd0);
    checkVal("abort div_by_zero", 32'(div_by_zero), 32'd0);
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkVal("abort no done", 32'(saw_done), 32'd0);
    applyStimulus(4'd8, 4'd2);
    checkOutput(5, 1'b0, 4'd7, 4'd7, "t8_2");

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b));
        checkOutput((b == 0) ? 1 : 5, 1'b0, 4'($urandom_range(15)),
                    4'($urandom_range(15)), "sweep");
      end
    end

    checkVal("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
